// File: rtl/trap_hazard_ctrl.sv
// Decode-side sequencing controller: load-use stalls, trap entry/return (freeze, drain, redirect)
// and the mepc/mcause/mtvec CSRs. Define TRAP_ILLEGAL_EN to add the id_illegal trap source.
module trap_hazard_ctrl #(
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0100,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic        id_is_ecall,
    input  logic        id_is_mret,
`ifdef TRAP_ILLEGAL_EN
    input  logic        id_illegal,
`endif
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        mtvec_we,
    input  logic [31:0] mtvec_wdata,
    output logic        stall_if,
    output logic        stall_id,
    output logic        flush_id,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] mepc,
    output logic [31:0] mcause,
    output logic [31:0] mtvec,
    output logic        busy
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES == 0) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DRAIN    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   drain_cnt;
    logic               to_mtvec_q;

    logic               illegal_c;
    logic               trap_req_c;
    logic               take_mtvec_c;
    logic               load_use_c;

`ifdef TRAP_ILLEGAL_EN
    assign illegal_c = id_valid & id_illegal;
`else
    assign illegal_c = 1'b0;
`endif

    // Illegal and ecall vector to mtvec; a bare mret returns to mepc.
    assign trap_req_c   = illegal_c | (id_valid & (id_is_ecall | id_is_mret));
    assign take_mtvec_c = illegal_c | id_is_ecall;
    assign load_use_c   = ex_memread & id_valid & (ex_rd != 5'd0) &
                          ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    // State, drain counter and trap CSRs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            drain_cnt  <= '0;
            to_mtvec_q <= 1'b0;
            mepc       <= 32'd0;
            mcause     <= 32'd0;
            mtvec      <= MTVEC_RESET & ~32'h3;
        end else begin
            if (mtvec_we) begin
                mtvec <= mtvec_wdata & ~32'h3;
            end
            case (state)
                S_IDLE: begin
                    if (trap_req_c) begin
                        to_mtvec_q <= take_mtvec_c;
                        drain_cnt  <= CNT_W'(DRAIN_CYCLES);
                        if (illegal_c) begin
                            mepc   <= id_pc;
                            mcause <= 32'd2;
                        end else if (id_is_ecall) begin
                            mepc   <= id_pc;
                            mcause <= 32'd11;
                        end
                        state <= (DRAIN_CYCLES == 0) ? S_REDIRECT : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Counter parks at 1 rather than wrapping.
                    if (drain_cnt <= CNT_W'(1)) begin
                        state <= S_REDIRECT;
                    end else begin
                        drain_cnt <= drain_cnt - CNT_W'(1);
                    end
                end
                S_REDIRECT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Pipeline controls decode from the current state; the trap cycle itself is frozen in IDLE.
    always_comb begin
        stall_if       = 1'b0;
        stall_id       = 1'b0;
        flush_id       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        busy           = 1'b0;
        case (state)
            S_IDLE: begin
                if (trap_req_c || load_use_c) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_id = 1'b1;
                end
            end
            S_DRAIN: begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_id = 1'b1;
                busy     = 1'b1;
            end
            S_REDIRECT: begin
                redirect_valid = 1'b1;
                flush_id       = 1'b1;
                busy           = 1'b1;
                redirect_pc    = to_mtvec_q ? mtvec : mepc;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_hazard_ctrl.sv
// Scoreboard bench for trap_hazard_ctrl: stimulus queues expected redirects, a monitor checks them;
// per-cycle control vectors and CSR values are checked directly.
module tb_trap_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic        id_is_ecall;
    logic        id_is_mret;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        mtvec_we;
    logic [31:0] mtvec_wdata;
    logic        stall_if;
    logic        stall_id;
    logic        flush_id;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtvec;
    logic        busy;
`ifdef TRAP_ILLEGAL_EN
    logic        id_illegal = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        int          at;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    trap_hazard_ctrl #(
        .MTVEC_RESET (32'h0000_0100),
        .DRAIN_CYCLES(3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_is_ecall   (id_is_ecall),
        .id_is_mret    (id_is_mret),
`ifdef TRAP_ILLEGAL_EN
        .id_illegal    (id_illegal),
`endif
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .ex_memread    (ex_memread),
        .ex_rd         (ex_rd),
        .mtvec_we      (mtvec_we),
        .mtvec_wdata   (mtvec_wdata),
        .stall_if      (stall_if),
        .stall_id      (stall_id),
        .flush_id      (flush_id),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .mepc          (mepc),
        .mcause        (mcause),
        .mtvec         (mtvec),
        .busy          (busy)
    );

    // Redirect monitor: every strobe must match the oldest queued expectation, pc and cycle.
    always @(negedge clk) begin
        if (redirect_valid === 1'b1) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL redirect_unexpected: got pc=0x%08h at cycle %0d, required none",
                         redirect_pc, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (redirect_pc !== mon_e.pc || cyc != mon_e.at) begin
                    errors = errors + 1;
                    $display("FAIL redirect: got pc=0x%08h cycle %0d, required pc=0x%08h cycle %0d",
                             redirect_pc, cyc, mon_e.pc, mon_e.at);
                end
            end
        end
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Checks {stall_if,stall_id,flush_id,redirect_valid,busy} for the current cycle, then advances.
    task automatic cyc_chk(input string name, input logic [4:0] exp);
        @(negedge clk);
        checks = checks + 1;
        if ({stall_if, stall_id, flush_id, redirect_valid, busy} !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got ctl=%05b, required %05b (cycle %0d)", name,
                     {stall_if, stall_id, flush_id, redirect_valid, busy}, exp, cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        id_valid    = 1'b0;
        id_pc       = 32'd0;
        id_is_ecall = 1'b0;
        id_is_mret  = 1'b0;
        id_rs1      = 5'd0;
        id_rs2      = 5'd0;
        ex_memread  = 1'b0;
        ex_rd       = 5'd0;
        mtvec_we    = 1'b0;
        mtvec_wdata = 32'd0;
    endtask

    task automatic present_trap(input logic [31:0] pc, input logic ecall, input logic mret,
                                input logic [31:0] target);
        id_valid    = 1'b1;
        id_pc       = pc;
        id_is_ecall = ecall;
        id_is_mret  = mret;
        exp_q.push_back('{pc: target, at: cyc + 4});
    endtask

    task automatic trap_seq(input string name, input logic [31:0] pc, input logic ecall,
                            input logic mret, input logic [31:0] target);
        present_trap(pc, ecall, mret, target);
        cyc_chk({name, "_detect"}, 5'b11100);
        clr_in();
        cyc_chk({name, "_drain1"}, 5'b11101);
        cyc_chk({name, "_drain2"}, 5'b11101);
        cyc_chk({name, "_drain3"}, 5'b11101);
        cyc_chk({name, "_redirect"}, 5'b00111);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        clr_in();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk32("reset_mtvec", mtvec, 32'h100);
        chk32("reset_mepc", mepc, 32'h0);
        chk32("reset_mcause", mcause, 32'h0);
        cyc_chk("reset_ctl", 5'b00000);

        // ecall at 0x40 vectors to mtvec
        trap_seq("ecall", 32'h40, 1'b1, 1'b0, 32'h100);
        chk32("ecall_mepc", mepc, 32'h40);
        chk32("ecall_mcause", mcause, 32'd11);
        cyc_chk("ecall_after", 5'b00000);

        // mret returns to mepc and leaves CSRs alone
        trap_seq("mret", 32'h80, 1'b0, 1'b1, 32'h40);
        chk32("mret_mepc", mepc, 32'h40);
        chk32("mret_mcause", mcause, 32'd11);

        // Load-use hazards
        id_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs1 = 5'd1;
        cyc_chk("lu_rs2", 5'b11100);
        clr_in();
        cyc_chk("lu_clear", 5'b00000);
        id_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        cyc_chk("lu_x0", 5'b00000);
        id_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd3;
        cyc_chk("lu_rs1", 5'b11100);
        id_valid = 1'b0;
        cyc_chk("lu_novalid", 5'b00000);
        clr_in();

        // Both flags: treated as ecall
        trap_seq("both", 32'hA0, 1'b1, 1'b1, 32'h100);
        chk32("both_mepc", mepc, 32'hA0);
        chk32("both_mcause", mcause, 32'd11);

        // mtvec write in first drain cycle is used by the redirect
        present_trap(32'h60, 1'b1, 1'b0, 32'h200);
        cyc_chk("wdrain_detect", 5'b11100);
        clr_in();
        mtvec_we = 1'b1; mtvec_wdata = 32'h203;
        cyc_chk("wdrain_drain1", 5'b11101);
        clr_in();
        chk32("wdrain_mtvec", mtvec, 32'h200);
        cyc_chk("wdrain_drain2", 5'b11101);
        cyc_chk("wdrain_drain3", 5'b11101);
        cyc_chk("wdrain_redirect", 5'b00111);
        chk32("wdrain_mepc", mepc, 32'h60);

        // mtvec write during redirect does not affect that redirect
        present_trap(32'h70, 1'b1, 1'b0, 32'h200);
        cyc_chk("wredir_detect", 5'b11100);
        clr_in();
        cyc_chk("wredir_drain1", 5'b11101);
        cyc_chk("wredir_drain2", 5'b11101);
        cyc_chk("wredir_drain3", 5'b11101);
        mtvec_we = 1'b1; mtvec_wdata = 32'h300;
        cyc_chk("wredir_redirect", 5'b00111);
        clr_in();
        chk32("wredir_mtvec", mtvec, 32'h300);

        // Reset in the second drain cycle abandons the trap
        id_valid = 1'b1; id_pc = 32'h90; id_is_ecall = 1'b1;
        cyc_chk("rst_detect", 5'b11100);
        clr_in();
        chk32("rst_mepc_pre", mepc, 32'h90);
        cyc_chk("rst_drain1", 5'b11101);
        rst = 1'b1;
        cyc_chk("rst_drain2", 5'b11101);
        rst = 1'b0;
        cyc_chk("rst_idle0", 5'b00000);
        chk32("rst_mepc", mepc, 32'h0);
        chk32("rst_mtvec", mtvec, 32'h100);
        cyc_chk("rst_idle1", 5'b00000);
        cyc_chk("rst_idle2", 5'b00000);
        cyc_chk("rst_idle3", 5'b00000);

        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL redirect_pending: got %0d outstanding, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
